touch_debounce_encoder: RTL and testbench
=========================================

// Module: touch_debounce_encoder
// PURPOSE
//  Generalised successor to the 4-pad touch decoder.
//  Synchronises and debounces N_CH touch pads, then encodes the active pad as a code (pad index + 1).
//  Emits press, release and long-press event pulses for the downstream addon logic.
//  Sits between the raw pad inputs and the edge controller/register interface.
// PARAMETERS
//  N_CH       4   number of touch pads (1..32)
//  OUT_W      4   code width; must satisfy 2**OUT_W > N_CH (elaboration error otherwise)
//  DB_CYCLES  16  consecutive stable cycles required to accept a pad change (>=1)
//  LONG_CYC   1000 cycles after press event before TOUCH_LONG fires; 0 disables long-press
//  MULTI_MODE 0   0: more than one debounced pad -> code 0; 1: lowest pressed index wins
// PORTS
//  CLK         in   1      system clock, all logic on rising edge
//  RST         in   1      synchronous, active-high reset
//  TOUCH_IN    in   N_CH   raw asynchronous pad levels, 1 = touched, bit i = pad i+1
//  TOUCH_OUT   out  OUT_W  registered code of current touch, 0 = none/invalid
//  TOUCH_VALID out  1      1-cycle pulse: new nonzero code loaded into TOUCH_OUT
//  TOUCH_REL   out  1      1-cycle pulse: code returned to 0 from nonzero
//  TOUCH_LONG  out  1      1-cycle pulse: same code held LONG_CYC cycles
//  TOUCH_DB    out  N_CH   debounced pad levels (status/debug)
// BEHAVIOUR
//  Reset (RST=1 at an edge): sync flops, debounced levels, counters, FSM -> 0/IDLE.
//   TOUCH_OUT=0, TOUCH_VALID=TOUCH_REL=TOUCH_LONG=0, TOUCH_DB=0.
//   Reset mid-press gives no TOUCH_REL. A pad still held after reset re-debounces and produces a fresh TOUCH_VALID.
//  Sync: 2-flop synchroniser per channel.
//  Debounce, per channel: counter clears whenever sync==TOUCH_DB[i] and increments while they differ.
//   TOUCH_DB[i] flips on the edge where the mismatch has lasted DB_CYCLES consecutive cycles; the counter then clears.
//   Glitches shorter than DB_CYCLES cycles never reach TOUCH_DB.
//  Decode (combinational from TOUCH_DB):
//   exactly one bit i set -> i+1.
//   none set -> 0.
//   multiple set -> 0 (MULTI_MODE=0) or lowest i+1 (MULTI_MODE=1).
//  Latency: input change first sampled at edge 0 -> TOUCH_DB at edge DB_CYCLES+1 -> TOUCH_OUT/pulses at edge DB_CYCLES+2.
//  FSM (registered), code = decoded value:
//   IDLE: code!=0 -> ACTIVE; load TOUCH_OUT=code; pulse TOUCH_VALID; clear hold counter.
//   ACTIVE, code==TOUCH_OUT: hold counter increments, saturating.
//    If LONG_CYC>0, TOUCH_LONG pulses once when the counter reaches LONG_CYC, i.e. LONG_CYC cycles after the TOUCH_VALID cycle.
//    No repeat until the next press event.
//   ACTIVE, code!=0 and !=TOUCH_OUT (direct pad change): load new code; pulse TOUCH_VALID; no TOUCH_REL; hold counter restarts; long-press re-armed.
//   ACTIVE, code==0: TOUCH_OUT=0; pulse TOUCH_REL; -> IDLE.
//  Pulses are mutually exclusive in any cycle; TOUCH_REL has priority over TOUCH_LONG.
//  Hold counter width: clog2(LONG_CYC+1); saturates, never wraps.
// TESTING (bench params DB_CYCLES=4, LONG_CYC=10, N_CH=4, OUT_W=4 unless noted)
//  1. TOUCH_IN=0001 from edge 0, held -> TOUCH_OUT=1 and TOUCH_VALID=1 at edge 6 only.
//     TOUCH_LONG at edge 16. Release -> TOUCH_REL one pulse; TOUCH_OUT=0.
//  2. Glitches: TOUCH_IN=0100 for 3 cycles, then 0 -> TOUCH_DB, TOUCH_OUT and all pulses stay 0.
//  3. Multi-touch, MULTI_MODE=0: 0010 held, then 1010 -> TOUCH_OUT 2 -> 0 with TOUCH_REL.
//     Same stimulus, MULTI_MODE=1 -> TOUCH_OUT stays 2; no pulses.
//  4. Direct change: 0001 held, then switch to 1000 with debounce edges aligned
//     -> TOUCH_OUT 1 -> 4 with TOUCH_VALID; no TOUCH_REL; long counter restarts.
//  5. Reset: RST=1 for 1 cycle while TOUCH_OUT=3 -> next edge all outputs 0, no TOUCH_REL.
//     Pad still held -> TOUCH_VALID with code 3 DB_CYCLES+3 edges after RST deasserts.
//  6. N_CH=8, OUT_W=4, LONG_CYC=0: press pad 8 (TOUCH_IN=8'h80) -> TOUCH_OUT=8; TOUCH_LONG never asserts.

Source files
------------

// File: rtl/touch_debounce_encoder.sv
// Touch pad front end: synchronises and debounces N_CH raw pad levels,
// encodes the active pad as (index + 1) and emits press, release and
// long-press pulses. Every output comes straight from a flop.
module touch_debounce_encoder #(
  parameter int N_CH       = 4,
  parameter int OUT_W      = 4,
  parameter int DB_CYCLES  = 16,
  parameter int LONG_CYC   = 1000,
  parameter int MULTI_MODE = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_CH-1:0]   TOUCH_IN,
  output logic [OUT_W-1:0]  TOUCH_OUT,
  output logic              TOUCH_VALID,
  output logic              TOUCH_REL,
  output logic              TOUCH_LONG,
  output logic [N_CH-1:0]   TOUCH_DB
);

  // Debounce counter only has to reach DB_CYCLES-1 before the level flips.
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  // Hold counter saturates at LONG_CYC; a zero LONG_CYC disables long-press.
  localparam int  HOLD_W  = (LONG_CYC > 0) ? $clog2(LONG_CYC + 1) : 1;
  localparam bit  LONG_EN = (LONG_CYC > 0);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((LONG_CYC > 0) ? (LONG_CYC - 1) : 0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  // Parameter sanity: the code must be able to represent every pad index + 1.
  if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
    $error("touch_debounce_encoder: N_CH must be in 1..32");
  end
  if ((64'd1 << OUT_W) <= 64'(N_CH)) begin : g_bad_outw
    $error("touch_debounce_encoder: 2**OUT_W must exceed N_CH");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("touch_debounce_encoder: DB_CYCLES must be >= 1");
  end

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [N_CH-1:0]   sync1_r;
  logic [N_CH-1:0]   sync2_r;
  logic [N_CH-1:0]   db_r;
  logic [DB_W-1:0]   db_cnt_r [N_CH];

  logic [OUT_W-1:0]  first_s;
  logic              found_s;
  logic              multi_s;
  logic [OUT_W-1:0]  code_s;

  state_t            state_r;
  state_t            state_n;
  logic [OUT_W-1:0]  out_r;
  logic [OUT_W-1:0]  out_n;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_n;
  logic              valid_r;
  logic              valid_n;
  logic              rel_r;
  logic              rel_n;
  logic              long_r;
  logic              long_n;

  // Two-flop synchroniser plus per-pad stability counter and debounced level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r <= '0;
      sync2_r <= '0;
      db_r    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= TOUCH_IN;
      sync2_r <= sync1_r;
      for (int i = 0; i < N_CH; i++) begin
        if (sync2_r[i] != db_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            db_r[i]     <= ~db_r[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Priority scan of the debounced pads: lowest set index, plus a multi-touch flag.
  always_comb begin
    first_s = '0;
    found_s = 1'b0;
    multi_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      multi_s = multi_s | (db_r[i] & found_s);
      if (db_r[i] && !found_s) begin
        first_s = OUT_W'(i + 1);
        found_s = 1'b1;
      end else begin
        first_s = first_s;
      end
    end
    if (multi_s && (MULTI_MODE == 0)) begin
      code_s = '0;
    end else begin
      code_s = first_s;
    end
  end

  // Next-state and pulse generation; pulses are exclusive by construction.
  always_comb begin
    state_n = state_r;
    out_n   = out_r;
    hold_n  = hold_r;
    valid_n = 1'b0;
    rel_n   = 1'b0;
    long_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (code_s != '0) begin
          state_n = ST_ACTIVE;
          out_n   = code_s;
          valid_n = 1'b1;
          hold_n  = '0;
        end else begin
          out_n   = '0;
        end
      end
      ST_ACTIVE: begin
        if (code_s == '0) begin
          state_n = ST_IDLE;
          out_n   = '0;
          rel_n   = 1'b1;
          hold_n  = '0;
        end else if (code_s != out_r) begin
          // Direct pad change: new press event, long-press re-armed.
          out_n   = code_s;
          valid_n = 1'b1;
          hold_n  = '0;
        end else if (hold_r != HOLD_MAX) begin
          hold_n = hold_r + HOLD_ONE;
          if (LONG_EN && (hold_r == HOLD_LAST)) begin
            long_n = 1'b1;
          end else begin
            long_n = 1'b0;
          end
        end else begin
          hold_n = hold_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
        out_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  // FSM state, code and pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      out_r   <= '0;
      hold_r  <= '0;
      valid_r <= 1'b0;
      rel_r   <= 1'b0;
      long_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      out_r   <= out_n;
      hold_r  <= hold_n;
      valid_r <= valid_n;
      rel_r   <= rel_n;
      long_r  <= long_n;
    end
  end

  assign TOUCH_OUT   = out_r;
  assign TOUCH_VALID = valid_r;
  assign TOUCH_REL   = rel_r;
  assign TOUCH_LONG  = long_r;
  assign TOUCH_DB    = db_r;

endmodule

// File: tb/tb_touch_debounce_encoder.sv
// Directed bench for touch_debounce_encoder. Three instances: MULTI_MODE 0 and 1
// (4 pads, long-press 10) and an 8-pad instance with long-press disabled.
// Expected pulse events are queued as stimulus is driven and matched against
// the events the monitors record.
module tb_touch_debounce_encoder;

  typedef struct packed {
    logic [1:0]  kind;   // 1 = VALID, 2 = REL, 3 = LONG
    logic [7:0]  code;
    logic [31:0] cyc;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [3:0] tin;
  logic [7:0] tin2;

  logic [3:0] out0, out1, out2;
  logic       val0, val1, val2;
  logic       rel0, rel1, rel2;
  logic       lng0, lng1, lng2;
  logic [3:0] db0, db1;
  logic [7:0] db2;

  int   cyc;
  int   total;
  int   bad;
  ev_t  exp_q [3][$];
  ev_t  obs_q [3][$];

  touch_debounce_encoder #(.N_CH(4), .OUT_W(4), .DB_CYCLES(4), .LONG_CYC(10), .MULTI_MODE(0)) dut0 (
    .CLK(clk), .RST(rst), .TOUCH_IN(tin), .TOUCH_OUT(out0), .TOUCH_VALID(val0),
    .TOUCH_REL(rel0), .TOUCH_LONG(lng0), .TOUCH_DB(db0));

  touch_debounce_encoder #(.N_CH(4), .OUT_W(4), .DB_CYCLES(4), .LONG_CYC(10), .MULTI_MODE(1)) dut1 (
    .CLK(clk), .RST(rst), .TOUCH_IN(tin), .TOUCH_OUT(out1), .TOUCH_VALID(val1),
    .TOUCH_REL(rel1), .TOUCH_LONG(lng1), .TOUCH_DB(db1));

  touch_debounce_encoder #(.N_CH(8), .OUT_W(4), .DB_CYCLES(4), .LONG_CYC(0), .MULTI_MODE(0)) dut2 (
    .CLK(clk), .RST(rst), .TOUCH_IN(tin2), .TOUCH_OUT(out2), .TOUCH_VALID(val2),
    .TOUCH_REL(rel2), .TOUCH_LONG(lng2), .TOUCH_DB(db2));

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every pulse of each instance on the falling edge.
  always @(negedge clk) begin
    if (val0 === 1'b1) obs_q[0].push_back({2'd1, 4'd0, out0, cyc});
    if (rel0 === 1'b1) obs_q[0].push_back({2'd2, 4'd0, out0, cyc});
    if (lng0 === 1'b1) obs_q[0].push_back({2'd3, 4'd0, out0, cyc});
    if (val1 === 1'b1) obs_q[1].push_back({2'd1, 4'd0, out1, cyc});
    if (rel1 === 1'b1) obs_q[1].push_back({2'd2, 4'd0, out1, cyc});
    if (lng1 === 1'b1) obs_q[1].push_back({2'd3, 4'd0, out1, cyc});
    if (val2 === 1'b1) obs_q[2].push_back({2'd1, 4'd0, out2, cyc});
    if (rel2 === 1'b1) obs_q[2].push_back({2'd2, 4'd0, out2, cyc});
    if (lng2 === 1'b1) obs_q[2].push_back({2'd3, 4'd0, out2, cyc});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic push(input int id, input int kind, input int code, input int at);
    ev_t e;
    e.kind = kind[1:0];
    e.code = code[7:0];
    e.cyc  = at;
    exp_q[id].push_back(e);
  endtask

  // Match queued expectations against recorded events, then demand no extras.
  task automatic drain(input int id, input string tag);
    ev_t e;
    ev_t o;
    while (exp_q[id].size() > 0) begin
      e = exp_q[id].pop_front();
      if (obs_q[id].size() > 0) o = obs_q[id].pop_front();
      else o = '0;
      chk($sformatf("%s_ev%0d", tag, id), 64'(o), 64'(e));
    end
    chk($sformatf("%s_extra%0d", tag, id), 64'(obs_q[id].size()), 64'd0);
    obs_q[id].delete();
  endtask

  task automatic drain_all(input string tag);
    for (int k = 0; k < 3; k++) drain(k, tag);
  endtask

  initial begin
    int c0;
    int c1;
    int r;
    cyc   = 0;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    tin   = 4'b0000;
    tin2  = 8'h00;
    tick(3);
    chk("rst_out0", 64'(out0), 64'd0);
    chk("rst_db0", 64'(db0), 64'd0);
    chk("rst_pulses0", 64'({val0, rel0, lng0}), 64'd0);
    chk("rst_out2", 64'(out2), 64'd0);
    chk("rst_db2", 64'(db2), 64'd0);
    rst = 1'b0;
    tick(2);

    // 1. Single press, long press, release.
    tin = 4'b0001;
    c0 = cyc + 1;
    push(0, 1, 1, c0 + 6); push(0, 3, 1, c0 + 16);
    push(1, 1, 1, c0 + 6); push(1, 3, 1, c0 + 16);
    tick_to(c0 + 4);
    chk("t1_db_e4", 64'(db0), 64'd0);
    tick_to(c0 + 5);
    chk("t1_db_e5", 64'(db0), 64'b0001);
    chk("t1_out_e5", 64'(out0), 64'd0);
    tick_to(c0 + 6);
    chk("t1_out_e6", 64'(out0), 64'd1);
    tick_to(c0 + 25);
    tin = 4'b0000;
    r = cyc + 1;
    push(0, 2, 0, r + 6); push(1, 2, 0, r + 6);
    tick_to(r + 8);
    chk("t1_out_rel", 64'(out0), 64'd0);
    drain_all("t1");

    // 2. Glitch shorter than the debounce window.
    tin = 4'b0100;
    tick(3);
    tin = 4'b0000;
    tick(12);
    chk("t2_db", 64'(db0), 64'd0);
    chk("t2_out", 64'(out0), 64'd0);
    drain_all("t2");

    // 3. Multi-touch: mode 0 drops to code 0, mode 1 keeps the lowest pad.
    tin = 4'b0010;
    c0 = cyc + 1;
    push(0, 1, 2, c0 + 6); push(1, 1, 2, c0 + 6);
    tick_to(c0 + 7);
    tin = 4'b1010;
    c1 = cyc + 1;
    push(0, 2, 0, c1 + 6);
    push(1, 3, 2, c0 + 16);
    tick_to(c1 + 7);
    chk("t3_db", 64'(db0), 64'b1010);
    chk("t3_out0", 64'(out0), 64'd0);
    chk("t3_out1", 64'(out1), 64'd2);
    tick_to(c0 + 20);
    tin = 4'b0000;
    r = cyc + 1;
    push(1, 2, 0, r + 6);
    tick_to(r + 8);
    chk("t3_out1_rel", 64'(out1), 64'd0);
    drain_all("t3");

    // 4. Direct pad change with aligned debounce edges.
    tin = 4'b0001;
    c0 = cyc + 1;
    push(0, 1, 1, c0 + 6); push(1, 1, 1, c0 + 6);
    tick_to(c0 + 8);
    tin = 4'b1000;
    c1 = cyc + 1;
    push(0, 1, 4, c1 + 6); push(0, 3, 4, c1 + 16);
    push(1, 1, 4, c1 + 6); push(1, 3, 4, c1 + 16);
    tick_to(c1 + 5);
    chk("t4_out_e5", 64'(out0), 64'd1);
    chk("t4_db_e5", 64'(db0), 64'b1000);
    tick_to(c1 + 6);
    chk("t4_out_e6", 64'(out0), 64'd4);
    tick_to(c1 + 20);
    tin = 4'b0000;
    r = cyc + 1;
    push(0, 2, 0, r + 6); push(1, 2, 0, r + 6);
    tick_to(r + 8);
    drain_all("t4");

    // 5. Reset while code 3 is active; pad stays held.
    tin = 4'b0100;
    c0 = cyc + 1;
    push(0, 1, 3, c0 + 6); push(1, 1, 3, c0 + 6);
    tick_to(c0 + 8);
    chk("t5_out_pre", 64'(out0), 64'd3);
    rst = 1'b1;
    r = cyc + 1;
    tick_to(r);
    chk("t5_out_rst", 64'(out0), 64'd0);
    chk("t5_db_rst", 64'(db0), 64'd0);
    chk("t5_pulse_rst", 64'({val0, rel0, lng0}), 64'd0);
    rst = 1'b0;
    push(0, 1, 3, r + 7); push(0, 3, 3, r + 17);
    push(1, 1, 3, r + 7); push(1, 3, 3, r + 17);
    tick_to(r + 6);
    chk("t5_out_e6", 64'(out0), 64'd0);
    tick_to(r + 7);
    chk("t5_out_e7", 64'(out0), 64'd3);
    tick_to(r + 20);
    tin = 4'b0000;
    c1 = cyc + 1;
    push(0, 2, 0, c1 + 6); push(1, 2, 0, c1 + 6);
    tick_to(c1 + 8);
    drain_all("t5");

    // 6. Eight pads, long-press disabled.
    tin2 = 8'h80;
    c0 = cyc + 1;
    push(2, 1, 8, c0 + 6);
    tick_to(c0 + 6);
    chk("t6_out_e6", 64'(out2), 64'd8);
    tick_to(c0 + 40);
    chk("t6_out_hold", 64'(out2), 64'd8);
    chk("t6_db", 64'(db2), 64'h80);
    tin2 = 8'h00;
    r = cyc + 1;
    push(2, 2, 0, r + 6);
    tick_to(r + 8);
    chk("t6_out_rel", 64'(out2), 64'd0);
    drain_all("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
